// File: rtl/lsu_dmem_port.sv
// Load/store unit data-memory port: IDLE/ACCESS/RESP handshake FSM with lane steering and load extension.
// Optional macro MISALIGN_TRAP_EN turns misaligned H/HU/W accesses into error responses.
module lsu_dmem_port #(
  parameter logic [31:0] DMEM_BASE  = 32'h0000_0000,
  parameter logic [31:0] DMEM_LIMIT = 32'h0003_FFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] daddr,
  output logic [31:0] dwdata,
  output logic [3:0]  dwe,
  input  logic [31:0] drdata
);

`ifdef MISALIGN_TRAP_EN
  localparam logic TRAP_MISALIGN = 1'b1;
`else
  localparam logic TRAP_MISALIGN = 1'b0;
`endif

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Offset-based window test avoids a constant-true compare when DMEM_BASE is 0.
  localparam logic [31:0] DMEM_SPAN = DMEM_LIMIT - DMEM_BASE;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } state_t;

  state_t state, state_next;

  logic       hs;
  logic       we_p0;
  logic [2:0] funct3_p0;
  logic [1:0] off_p0;
  logic       err_p0;

  function automatic logic access_err(input logic we, input logic [2:0] f3, input logic [31:0] addr);
    logic bad;
    case (f3)
      F3_B, F3_H, F3_W: bad = 1'b0;
      F3_BU, F3_HU:     bad = we;
      default:          bad = 1'b1;
    endcase
    if ((addr - DMEM_BASE) > DMEM_SPAN) bad = 1'b1;
    if (TRAP_MISALIGN) begin
      if ((f3 == F3_H || f3 == F3_HU) && addr[0]) bad = 1'b1;
      if (f3 == F3_W && addr[1:0] != 2'b00)       bad = 1'b1;
    end
    return bad;
  endfunction

  // Untrapped misaligned halves/words fall back to their natural alignment.
  function automatic logic [1:0] align_off(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_H, F3_HU: return {off[1], 1'b0};
      F3_W:        return 2'b00;
      default:     return off;
    endcase
  endfunction

  function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] wd);
    case (f3)
      F3_B:    return {4{wd[7:0]}};
      F3_H:    return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  function automatic logic [3:0] lane_mask(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_B:    return 4'b0001 << off;
      F3_H:    return 4'b0011 << {off[1], 1'b0};
      F3_W:    return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(d >> {off, 3'b000});
    h = off[1] ? d[31:16] : d[15:0];
    case (f3)
      F3_B:    return {{24{b[7]}}, b};
      F3_BU:   return {24'h0, b};
      F3_H:    return {{16{h[15]}}, h};
      F3_HU:   return {16'h0, h};
      default: return d;
    endcase
  endfunction

  assign req_ready = !reset && (state != ACCESS);
  assign hs        = req_valid && req_ready;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (hs) state_next = ACCESS;
      ACCESS:  state_next = RESP;
      RESP:    state_next = hs ? ACCESS : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request capture stage: decoded once at acceptance, consumed during ACCESS.
  always_ff @(posedge clk) begin
    if (hs) begin
      we_p0     <= req_we;
      funct3_p0 <= req_funct3;
      off_p0    <= align_off(req_funct3, req_addr[1:0]);
      err_p0    <= access_err(req_we, req_funct3, req_addr);
    end
  end

  // Memory-side address/data are launched at acceptance so they are stable for all of ACCESS.
  always_ff @(posedge clk) begin
    if (reset) begin
      daddr  <= 32'h0;
      dwdata <= 32'h0;
    end else if (hs) begin
      daddr  <= {req_addr[31:2], 2'b00};
      dwdata <= store_lanes(req_funct3, req_wdata);
    end
  end

  assign dwe = (state == ACCESS && we_p0 && !err_p0 && !reset) ? lane_mask(funct3_p0, off_p0) : 4'b0000;

  // Response stage: load data sampled at the end of ACCESS, presented during RESP.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= 32'h0;
    end else if (state == ACCESS) begin
      rsp_valid <= 1'b1;
      rsp_err   <= err_p0;
      rsp_rdata <= (err_p0 || we_p0) ? 32'h0 : load_extend(funct3_p0, off_p0, drdata);
    end else begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lsu_dmem_port.sv
// Directed bench for lsu_dmem_port with a byte-lane memory model behind the port.
module tb_lsu_dmem_port;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] daddr;
  logic [31:0] dwdata;
  logic [3:0]  dwe;
  logic [31:0] drdata;

  int tests_run = 0;
  int fails = 0;

  logic [31:0] mem [0:1023] = '{default: 32'h0};

  lsu_dmem_port dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .daddr(daddr), .dwdata(dwdata), .dwe(dwe), .drdata(drdata)
  );

  always #5 clk = ~clk;

  assign drdata = mem[daddr[11:2]];
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (dwe[i]) mem[daddr[11:2]][8*i +: 8] <= dwdata[8*i +: 8];
  end

  // One complete transaction from IDLE; observations from the ACCESS and RESP cycles.
  task automatic do_access(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                           output logic rdy_idle, output logic rdy_acc, output logic [3:0] we_o,
                           output logic [31:0] da_o, output logic [31:0] dw_o,
                           output logic rv, output logic [31:0] rd, output logic er);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    rdy_idle = req_ready;
    @(negedge clk);
    req_valid = 1'b0;
    rdy_acc = req_ready; we_o = dwe; da_o = daddr; dw_o = dwdata;
    @(negedge clk);
    rv = rsp_valid; rd = rsp_rdata; er = rsp_err;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    tests_run++; if (req_ready !== 1'b0) begin fails++; $display("FAIL reset_ready got=%b exp=0", req_ready); end
    tests_run++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    tests_run++; if (rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin fails++; $display("FAIL reset_rsp got=%h/%b exp=0/0", rsp_rdata, rsp_err); end
    tests_run++; if (daddr !== 32'h0 || dwdata !== 32'h0 || dwe !== 4'h0) begin fails++; $display("FAIL reset_mem got=%h/%h/%b exp=0", daddr, dwdata, dwe); end
    reset = 1'b0;
    #1;
    tests_run++; if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_release_ready got=%b exp=1", req_ready); end
  endtask

  task automatic test_word;
    logic r0, r1, rv, er; logic [3:0] w; logic [31:0] da, dw, rd;
    do_access(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, r0, r1, w, da, dw, rv, rd, er);
    tests_run++; if (r0 !== 1'b1 || r1 !== 1'b0) begin fails++; $display("FAIL sw_ready got=%b%b exp=10", r0, r1); end
    tests_run++; if (w !== 4'b1111 || dw !== 32'hDEADBEEF || da !== 32'h100) begin fails++; $display("FAIL sw_access got=%b/%h/%h exp=1111/deadbeef/100", w, dw, da); end
    tests_run++; if (rv !== 1'b1 || er !== 1'b0 || rd !== 32'h0) begin fails++; $display("FAIL sw_rsp got=%b/%b/%h exp=1/0/0", rv, er, rd); end
    do_access(1'b0, 3'b010, 32'h100, 32'h0, r0, r1, w, da, dw, rv, rd, er);
    tests_run++; if (w !== 4'b0000) begin fails++; $display("FAIL lw_dwe got=%b exp=0000", w); end
    tests_run++; if (rv !== 1'b1 || er !== 1'b0 || rd !== 32'hDEADBEEF) begin fails++; $display("FAIL lw_rsp got=%b/%b/%h exp=1/0/deadbeef", rv, er, rd); end
  endtask

  task automatic test_byte;
    logic r0, r1, rv, er; logic [3:0] w; logic [31:0] da, dw, rd;
    do_access(1'b1, 3'b000, 32'h103, 32'h0000_0080, r0, r1, w, da, dw, rv, rd, er);
    tests_run++; if (w !== 4'b1000 || dw !== 32'h80808080 || da !== 32'h100) begin fails++; $display("FAIL sb_access got=%b/%h/%h exp=1000/80808080/100", w, dw, da); end
    do_access(1'b0, 3'b000, 32'h103, 32'h0, r0, r1, w, da, dw, rv, rd, er);
    tests_run++; if (rv !== 1'b1 || rd !== 32'hFFFFFF80) begin fails++; $display("FAIL lb_rsp got=%b/%h exp=1/ffffff80", rv, rd); end
    do_access(1'b0, 3'b100, 32'h103, 32'h0, r0, r1, w, da, dw, rv, rd, er);
    tests_run++; if (rv !== 1'b1 || rd !== 32'h00000080 || er !== 1'b0) begin fails++; $display("FAIL lbu_rsp got=%b/%h/%b exp=1/00000080/0", rv, rd, er); end
    do_access(1'b0, 3'b010, 32'h100, 32'h0, r0, r1, w, da, dw, rv, rd, er);
    tests_run++; if (rd !== 32'h80ADBEEF) begin fails++; $display("FAIL sb_merge got=%h exp=80adbeef", rd); end
  endtask

  task automatic test_half;
    logic r0, r1, rv, er; logic [3:0] w; logic [31:0] da, dw, rd;
    do_access(1'b1, 3'b001, 32'h102, 32'h0000_8001, r0, r1, w, da, dw, rv, rd, er);
    tests_run++; if (w !== 4'b1100 || dw !== 32'h80018001) begin fails++; $display("FAIL sh_access got=%b/%h exp=1100/80018001", w, dw); end
    do_access(1'b0, 3'b001, 32'h102, 32'h0, r0, r1, w, da, dw, rv, rd, er);
    tests_run++; if (rd !== 32'hFFFF8001 || er !== 1'b0) begin fails++; $display("FAIL lh_rsp got=%h/%b exp=ffff8001/0", rd, er); end
    do_access(1'b0, 3'b101, 32'h102, 32'h0, r0, r1, w, da, dw, rv, rd, er);
    tests_run++; if (rd !== 32'h00008001) begin fails++; $display("FAIL lhu_rsp got=%h exp=00008001", rd); end
    do_access(1'b1, 3'b001, 32'h101, 32'h0000_1234, r0, r1, w, da, dw, rv, rd, er);
`ifdef MISALIGN_TRAP_EN
    tests_run++; if (w !== 4'b0000 || er !== 1'b1 || rd !== 32'h0) begin fails++; $display("FAIL sh_misalign got=%b/%b/%h exp=0000/1/0", w, er, rd); end
`else
    tests_run++; if (w !== 4'b0011 || er !== 1'b0 || dw !== 32'h12341234) begin fails++; $display("FAIL sh_misalign got=%b/%b/%h exp=0011/0/12341234", w, er, dw); end
`endif
    do_access(1'b0, 3'b010, 32'h100, 32'h0, r0, r1, w, da, dw, rv, rd, er);
`ifdef MISALIGN_TRAP_EN
    tests_run++; if (rd !== 32'h8001BEEF) begin fails++; $display("FAIL sh_misalign_mem got=%h exp=8001beef", rd); end
`else
    tests_run++; if (rd !== 32'h80011234) begin fails++; $display("FAIL sh_misalign_mem got=%h exp=80011234", rd); end
`endif
  endtask

  task automatic test_errors;
    logic r0, r1, rv, er; logic [3:0] w; logic [31:0] da, dw, rd;
    do_access(1'b1, 3'b010, 32'h40000, 32'h12345678, r0, r1, w, da, dw, rv, rd, er);
    tests_run++; if (w !== 4'b0000 || er !== 1'b1 || rv !== 1'b1 || rd !== 32'h0) begin fails++; $display("FAIL err_range_store got=%b/%b/%b/%h exp=0000/1/1/0", w, er, rv, rd); end
    do_access(1'b0, 3'b010, 32'h0, 32'h0, r0, r1, w, da, dw, rv, rd, er);
    tests_run++; if (rd !== 32'h0 || er !== 1'b0) begin fails++; $display("FAIL err_mem_unchanged got=%h/%b exp=0/0", rd, er); end
    do_access(1'b1, 3'b011, 32'h100, 32'hFFFFFFFF, r0, r1, w, da, dw, rv, rd, er);
    tests_run++; if (w !== 4'b0000 || er !== 1'b1) begin fails++; $display("FAIL err_f3_011 got=%b/%b exp=0000/1", w, er); end
    do_access(1'b0, 3'b110, 32'h100, 32'h0, r0, r1, w, da, dw, rv, rd, er);
    tests_run++; if (rd !== 32'h0 || er !== 1'b1) begin fails++; $display("FAIL err_f3_110 got=%h/%b exp=0/1", rd, er); end
    do_access(1'b1, 3'b100, 32'h100, 32'h55, r0, r1, w, da, dw, rv, rd, er);
    tests_run++; if (w !== 4'b0000 || er !== 1'b1) begin fails++; $display("FAIL err_store_bu got=%b/%b exp=0000/1", w, er); end
    do_access(1'b0, 3'b010, 32'h3FFFC, 32'h0, r0, r1, w, da, dw, rv, rd, er);
    tests_run++; if (er !== 1'b0 || rv !== 1'b1) begin fails++; $display("FAIL err_limit_edge got=%b/%b exp=0/1", er, rv); end
  endtask

  task automatic test_back_to_back;
    logic r0, r1, rv, er; logic [3:0] w; logic [31:0] da, dw, rd;
    logic [31:0] addrs [0:3];
    logic [31:0] exps [0:2];
    do_access(1'b1, 3'b010, 32'h104, 32'h11111111, r0, r1, w, da, dw, rv, rd, er);
    do_access(1'b1, 3'b010, 32'h108, 32'h22222222, r0, r1, w, da, dw, rv, rd, er);
    addrs[0] = 32'h100; addrs[1] = 32'h104; addrs[2] = 32'h108; addrs[3] = 32'h10C;
`ifdef MISALIGN_TRAP_EN
    exps[0] = 32'h8001BEEF;
`else
    exps[0] = 32'h80011234;
`endif
    exps[1] = 32'h11111111; exps[2] = 32'h22222222;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = addrs[0];
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      tests_run++; if (req_ready !== 1'b0 || rsp_valid !== 1'b0) begin fails++; $display("FAIL b2b_access%0d got=%b/%b exp=0/0", k, req_ready, rsp_valid); end
      req_addr = addrs[k+1];
      @(negedge clk);
      tests_run++; if (rsp_valid !== 1'b1 || rsp_rdata !== exps[k] || req_ready !== 1'b1) begin fails++; $display("FAIL b2b_resp%0d got=%b/%h/%b exp=1/%h/1", k, rsp_valid, rsp_rdata, req_ready, exps[k]); end
      if (k == 2) req_valid = 1'b0;
    end
    @(negedge clk);
    tests_run++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin fails++; $display("FAIL b2b_idle got=%b/%b exp=0/1", rsp_valid, req_ready); end
  endtask

  task automatic test_reset_mid;
    logic r0, r1, rv, er; logic [3:0] w; logic [31:0] da, dw, rd;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h104; req_wdata = 32'hAAAAAAAA;
    @(negedge clk);
    req_valid = 1'b0;
    reset = 1'b1;
    #1;
    tests_run++; if (dwe !== 4'b0000 || req_ready !== 1'b0) begin fails++; $display("FAIL rst_mid_access got=%b/%b exp=0000/0", dwe, req_ready); end
    @(negedge clk);
    tests_run++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL rst_mid_no_rsp got=%b exp=0", rsp_valid); end
    reset = 1'b0;
    #1;
    tests_run++; if (req_ready !== 1'b1) begin fails++; $display("FAIL rst_mid_ready got=%b exp=1", req_ready); end
    @(negedge clk);
    tests_run++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL rst_mid_after got=%b exp=0", rsp_valid); end
    do_access(1'b0, 3'b010, 32'h104, 32'h0, r0, r1, w, da, dw, rv, rd, er);
    tests_run++; if (rd !== 32'h11111111 || rv !== 1'b1) begin fails++; $display("FAIL rst_mid_mem got=%h/%b exp=11111111/1", rd, rv); end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/lsu_dmem_port.md
LSU_DMEM_PORT -- requirements
Module: lsu_dmem_port

Interface
Parameters:
REQ-001 The block SHALL have parameter DMEM_BASE, default 32'h0000_0000, meaning the lowest byte address it accepts.
REQ-002 The block SHALL have parameter DMEM_LIMIT, default 32'h0003_FFFF, meaning the highest byte address it accepts (inclusive).

Ports:
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on posedge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port req_valid, input, 1 bit: the CPU access request is valid.
REQ-006 The block SHALL have port req_ready, output, 1 bit: the block accepts a request this cycle.
REQ-007 The block SHALL have port req_we, input, 1 bit: 1 = store, 0 = load.
REQ-008 The block SHALL have port req_funct3, input, 3 bits: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-009 The block SHALL have port req_addr, input, 32 bits: byte address.
REQ-010 The block SHALL have port req_wdata, input, 32 bits: store data, right-aligned.
REQ-011 The block SHALL have port rsp_valid, output, 1 bit: one-cycle response strobe.
REQ-012 The block SHALL have port rsp_rdata, output, 32 bits: extended load data (0 for stores and errors).
REQ-013 The block SHALL have port rsp_err, output, 1 bit: access error flag, valid with rsp_valid.
REQ-014 The block SHALL have port daddr, output, 32 bits: memory address, bits [1:0] always 0.
REQ-015 The block SHALL have port dwdata, output, 32 bits: lane-replicated store data.
REQ-016 The block SHALL have port dwe, output, 4 bits: per-byte write enables, bit n = byte lane n.
REQ-017 The block SHALL have port drdata, input, 32 bits: asynchronous memory read data.

Function
REQ-018 FSM states SHALL be IDLE, ACCESS and RESP; req_ready SHALL be 1 in IDLE and RESP and 0 in ACCESS.
REQ-019 A handshake (req_valid && req_ready) SHALL register we/funct3/addr/wdata and enter ACCESS next cycle.
REQ-020 ACCESS SHALL last exactly one cycle: daddr/dwdata/dwe are driven from registered request; load data is sampled from drdata at the end of it.
REQ-021 RESP SHALL assert rsp_valid for one cycle; on a same-cycle handshake go to ACCESS, else to IDLE; load latency is 2 cycles from acceptance to rsp_valid.
REQ-022 dwe SHALL be 0 outside ACCESS, during loads, on any error, and whenever reset=1.
REQ-023 Store B: dwdata={4{wdata[7:0]}}, dwe=4'b0001<<addr[1:0]; H: dwdata={2{wdata[15:0]}}, dwe=4'b0011<<{addr[1],1'b0}; W: dwdata=wdata, dwe=4'b1111.
REQ-024 Load: select byte/half by addr[1:0]/addr[1]; B/H sign-extend, BU/HU zero-extend, W passthrough.
REQ-025 Error SHALL be flagged for funct3 011/110/111, store with funct3 100/101, or addr outside [DMEM_BASE, DMEM_LIMIT]; error accesses SHALL write nothing and return rsp_rdata=0, rsp_err=1.
REQ-026 daddr SHALL hold its last value outside ACCESS (0 after reset).

Reset
REQ-027 Reset SHALL force state IDLE, rsp_valid=0, rsp_err=0, rsp_rdata=0, daddr=0, dwdata=0, and drop any in-flight request without response.
REQ-028 req_ready SHALL be 0 while reset=1 and 1 in the first cycle after reset deasserts.

Configuration
REQ-029 With macro MISALIGN_TRAP_EN defined, H/HU with addr[0]=1 or W with addr[1:0]!=0 SHALL be an error per REQ-025.
REQ-030 Without MISALIGN_TRAP_EN, such accesses SHALL proceed with address bits forced to natural alignment (H: addr[0]=0; W: addr[1:0]=0), with no error.

Verification
REQ-031 Store W 32'hDEADBEEF @ 0x100, then load W @ 0x100 -> dwe=1111 in ACCESS, rsp_rdata=32'hDEADBEEF, rsp_err=0, rsp_valid 2 cycles after acceptance.
REQ-032 Store B 8'h80 @ 0x103, then load B and BU @ 0x103 -> dwe=1000, dwdata=32'h80808080; rsp_rdata=32'hFFFFFF80 then 32'h00000080.
REQ-033 Back-to-back loads with req_valid held high -> one acceptance every 2 cycles, rsp_valid in each RESP cycle, responses in order.
REQ-034 Load H @ 0x102 containing 16'h8001 -> 32'hFFFF8001; store H @ 0x101 -> with MISALIGN_TRAP_EN: rsp_err=1, dwe=0; without: dwe=0011.
REQ-035 Store W @ 0x40000 and funct3=011 -> rsp_err=1, dwe stays 0, memory unchanged.
REQ-036 Assert reset during ACCESS of a store -> dwe=0 that cycle, no rsp_valid, IDLE with req_ready=1 after release.
